// File: rtl/muldiv_pkg.sv
// Shared types and constants for the muldiv scheduler.
//   W / HALF       : datapath operand width and legal operand width
//   OP_MUL / OP_DIV: encoding of req_op
//   state_e        : scheduler state encoding
//   op_err()       : operand screening applied when a request is accepted
package muldiv_pkg;

  localparam int unsigned W    = 20;
  localparam int unsigned HALF = 10;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_FIRE  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // MUL operands must fit HALF bits; DIV needs a nonzero HALF-bit divisor and a
  // quotient that fits HALF bits, i.e. a < (b << HALF).
  function automatic logic op_err(input logic op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    logic [2*W-1:0] b_sh;
    b_sh = {{W{1'b0}}, b} << HALF;
    if (op == OP_MUL) begin
      return (a[W-1:HALF] != '0) || (b[W-1:HALF] != '0);
    end
    return (b == '0) || (b[W-1:HALF] != '0) || ({{W{1'b0}}, a} >= b_sh);
  endfunction

endpackage

// File: rtl/muldiv_sched_if.sv
// Request/response bus between client blocks and muldiv_sched.
//   req_valid/req_ready/req_op/req_a/req_b : per-requester request channel
//   rsp_valid/rsp_ready/rsp_id/rsp_q/rsp_r/rsp_err : shared tagged response
// master = client side, slave = scheduler side.
interface muldiv_sched_if
  import muldiv_pkg::*;
#(
  parameter int unsigned NREQ = 4
);

  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [W-1:0]      rsp_q;
  logic [W-1:0]      rsp_r;
  logic              rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err
  );

endinterface

// File: rtl/muldiv_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester after i_last.
//   i_valid : request vector
//   i_last  : index of the previously granted requester
//   o_grant : one-hot grant (all zero when nothing is valid)
//   o_idx   : index of the granted requester
//   o_any   : some requester is granted
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         i_valid,
  input  logic [$clog2(NREQ)-1:0] i_last,
  output logic [NREQ-1:0]         o_grant,
  output logic [$clog2(NREQ)-1:0] o_idx,
  output logic                    o_any
);

  localparam int unsigned IW = $clog2(NREQ);

  // Scan i_last+1 .. i_last+NREQ (mod NREQ); i_last itself is checked last.
  always_comb begin
    int unsigned w_c;
    w_c     = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_c = (32'(i_last) + k) % NREQ;
      if (!o_any && i_valid[IW'(w_c)]) begin
        o_any = 1'b1;
        o_idx = IW'(w_c);
      end
    end
    if (o_any) o_grant[o_idx] = 1'b1;
  end

endmodule

// File: rtl/muldiv_sched.sv
// Round-robin scheduler sharing one multiply/divide datapath among NREQ
// requesters. Screens operands, triggers the datapath, waits LAT cycles,
// captures the result and returns it on a tagged response channel.
//   t, rst_n        : clock, async active-low reset
//   bus             : request/response channels (slave side)
//   dp_go/dp_a/dp_b : datapath trigger and operands
//   dp_p/dp_n/dp_r  : datapath product, quotient, remainder
//   busy            : scheduler not idle
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 1
) (
  input  logic         t,
  input  logic         rst_n,
  muldiv_sched_if.slave bus,
  output logic         dp_go,
  output logic [W-1:0] dp_a,
  output logic [W-1:0] dp_b,
  input  logic [W-1:0] dp_p,
  input  logic [W-1:0] dp_n,
  input  logic [W-1:0] dp_r,
  output logic         busy
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = 4;

  localparam logic [2:0] S_IDLE  = 3'(ST_IDLE);
  localparam logic [2:0] S_ISSUE = 3'(ST_ISSUE);
  localparam logic [2:0] S_FIRE  = 3'(ST_FIRE);
  localparam logic [2:0] S_WAIT  = 3'(ST_WAIT);
  localparam logic [2:0] S_RESP  = 3'(ST_RESP);

  logic [2:0]    r_state,     w_state_nxt;
  logic [IW-1:0] r_last,      w_last_nxt;
  logic          r_op,        w_op_nxt;
  logic [CW-1:0] r_cnt,       w_cnt_nxt;
  logic          r_rsp_valid, w_rsp_valid_nxt;
  logic [IW-1:0] r_rsp_id,    w_rsp_id_nxt;
  logic [W-1:0]  r_rsp_q,     w_rsp_q_nxt;
  logic [W-1:0]  r_rsp_r,     w_rsp_r_nxt;
  logic          r_rsp_err,   w_rsp_err_nxt;
  logic          r_dp_go,     w_dp_go_nxt;
  logic [W-1:0]  r_dp_a,      w_dp_a_nxt;
  logic [W-1:0]  r_dp_b,      w_dp_b_nxt;
  logic          r_busy,      w_busy_nxt;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_sel_op;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic            w_sel_err;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_valid (bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Grant is offered only while idle and out of reset.
  assign bus.req_ready = (rst_n && (r_state == S_IDLE)) ? w_grant : '0;

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_op = 1'b0;
    w_sel_a  = '0;
    w_sel_b  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op = bus.req_op[i];
        w_sel_a  = bus.req_a[i*W +: W];
        w_sel_b  = bus.req_b[i*W +: W];
      end
    end
  end

  assign w_sel_err = op_err(w_sel_op, w_sel_a, w_sel_b);

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_op_nxt        = r_op;
    w_cnt_nxt       = r_cnt;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_id_nxt    = r_rsp_id;
    w_rsp_q_nxt     = r_rsp_q;
    w_rsp_r_nxt     = r_rsp_r;
    w_rsp_err_nxt   = r_rsp_err;
    w_dp_go_nxt     = 1'b0;
    w_dp_a_nxt      = r_dp_a;
    w_dp_b_nxt      = r_dp_b;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_last_nxt   = w_idx;
          w_op_nxt     = w_sel_op;
          w_rsp_id_nxt = w_idx;
          if (w_sel_err) begin
            // Rejected ops never reach the datapath.
            w_rsp_err_nxt = 1'b1;
            w_rsp_q_nxt   = '0;
            w_rsp_r_nxt   = '0;
            w_state_nxt   = S_RESP;
          end else begin
            w_dp_a_nxt  = w_sel_a;
            w_dp_b_nxt  = w_sel_b;
            w_state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        w_dp_go_nxt = 1'b1;
        w_state_nxt = S_FIRE;
      end
      S_FIRE: begin
        w_cnt_nxt   = CW'(LAT);
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt <= CW'(1)) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_q_nxt     = (r_op == OP_MUL) ? dp_p : dp_n;
          w_rsp_r_nxt     = (r_op == OP_MUL) ? '0 : dp_r;
          w_state_nxt     = S_RESP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RESP: begin
        // Error path arrives here with rsp_valid still low; raise it one cycle later.
        if (!r_rsp_valid) begin
          w_rsp_valid_nxt = 1'b1;
        end else if (bus.rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge t or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= IW'(NREQ - 1);
      r_op        <= 1'b0;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_q     <= '0;
      r_rsp_r     <= '0;
      r_rsp_err   <= 1'b0;
      r_dp_go     <= 1'b0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_op        <= w_op_nxt;
      r_cnt       <= w_cnt_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_id    <= w_rsp_id_nxt;
      r_rsp_q     <= w_rsp_q_nxt;
      r_rsp_r     <= w_rsp_r_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_dp_go     <= w_dp_go_nxt;
      r_dp_a      <= w_dp_a_nxt;
      r_dp_b      <= w_dp_b_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_q     = r_rsp_q;
  assign bus.rsp_r     = r_rsp_r;
  assign bus.rsp_err   = r_rsp_err;
  assign dp_go         = r_dp_go;
  assign dp_a          = r_dp_a;
  assign dp_b          = r_dp_b;
  assign busy          = r_busy;

endmodule

// File: tb/tb_muldiv_sched.sv
// Testbench for muldiv_sched: behavioural datapath stand-in, a transaction-level
// reference model checked every cycle, and directed vectors with literal results.
module tb_muldiv_sched;
  import muldiv_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 1;

  logic        t = 1'b0;
  logic        rst_n;
  logic        dp_go;
  logic [19:0] dp_a, dp_b;
  logic [19:0] dp_p = '0, dp_n = '0, dp_r = '0;
  logic        busy;
  int          go_cnt = 0;

  int n_total = 0;
  int n_pass  = 0;

  muldiv_sched_if #(.NREQ(NREQ)) bus ();

  muldiv_sched #(.NREQ(NREQ), .LAT(LAT)) dut (
    .t     (t),
    .rst_n (rst_n),
    .bus   (bus),
    .dp_go (dp_go),
    .dp_a  (dp_a),
    .dp_b  (dp_b),
    .dp_p  (dp_p),
    .dp_n  (dp_n),
    .dp_r  (dp_r),
    .busy  (busy)
  );

  always #5 t = ~t;

  // Datapath stand-in: results appear on the trigger's rising edge.
  always @(posedge dp_go) begin
    go_cnt = go_cnt + 1;
    dp_p   = 20'(40'(dp_a) * 40'(dp_b));
    if (dp_b != '0) begin
      dp_n = dp_a / dp_b;
      dp_r = dp_a % dp_b;
    end
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // ---------------- reference model ----------------
  bit          m_busy = 1'b0;
  bit          m_err  = 1'b0;
  int          m_k    = 0;
  int          m_last = NREQ - 1;
  int          m_id   = 0;
  logic [19:0] m_q = '0, m_r = '0, m_a = '0, m_b = '0;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    int c;
    for (int k = 1; k <= NREQ; k++) begin
      c = (last + k) % NREQ;
      if (v[2'(c)]) return c;
    end
    return -1;
  endfunction

  always @(negedge t) begin : cmp
    logic [NREQ-1:0] eg;
    logic [19:0]     a, b;
    logic            op;
    bit              rv;
    int              g;
    if (!rst_n) begin
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_id",    32'(bus.rsp_id), 0);
      check("rst_rsp_q",     32'(bus.rsp_q), 0);
      check("rst_rsp_r",     32'(bus.rsp_r), 0);
      check("rst_rsp_err",   32'(bus.rsp_err), 0);
      check("rst_dp_go",     32'(dp_go), 0);
      check("rst_dp_a",      32'(dp_a), 0);
      check("rst_dp_b",      32'(dp_b), 0);
      check("rst_busy",      32'(busy), 0);
      m_busy = 1'b0;
      m_last = NREQ - 1;
      m_k    = 0;
    end else begin
      eg = '0;
      g  = -1;
      if (!m_busy) begin
        g = rr_pick(bus.req_valid, m_last);
        if (g >= 0) eg[2'(g)] = 1'b1;
      end
      rv = m_busy && (m_k >= (m_err ? 1 : 2 + int'(LAT)));
      check("req_ready", 32'(bus.req_ready), 32'(eg));
      check("busy",      32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
      check("dp_go",     32'(dp_go), 32'(m_busy && !m_err && m_k == 1));
      if (rv) begin
        check("rsp_id",  32'(bus.rsp_id), 32'(m_id));
        check("rsp_q",   32'(bus.rsp_q), 32'(m_q));
        check("rsp_r",   32'(bus.rsp_r), 32'(m_r));
        check("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end
      if (m_busy && !m_err) begin
        check("dp_a", 32'(dp_a), 32'(m_a));
        check("dp_b", 32'(dp_b), 32'(m_b));
      end
      // Predict the effect of the coming edge.
      if (!m_busy) begin
        if (g >= 0) begin
          a  = 20'(bus.req_a >> (20 * g));
          b  = 20'(bus.req_b >> (20 * g));
          op = bus.req_op[2'(g)];
          if (op == OP_MUL) begin
            m_err = (a >= 20'd1024) || (b >= 20'd1024);
            m_q   = m_err ? 20'd0 : 20'(a * b);
            m_r   = 20'd0;
          end else begin
            m_err = (b == 20'd0) || (b >= 20'd1024) ||
                    (32'(a) >= 32'(b) * 32'd1024);
            m_q   = m_err ? 20'd0 : a / b;
            m_r   = m_err ? 20'd0 : a % b;
          end
          m_a    = a;
          m_b    = b;
          m_id   = g;
          m_last = g;
          m_busy = 1'b1;
          m_k    = 0;
        end
      end else if (rv && bus.rsp_ready) begin
        m_busy = 1'b0;
      end else begin
        m_k = m_k + 1;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic op, input logic [19:0] a,
                         input logic [19:0] b);
    bus.req_op[2'(i)]    = op;
    bus.req_a[i*20 +: 20] = a;
    bus.req_b[i*20 +: 20] = b;
  endtask

  // Raise valid, wait for the grant, drop valid right after the accept edge.
  task automatic send(input int i, input logic op, input logic [19:0] a,
                      input logic [19:0] b);
    int n;
    @(posedge t); #1;
    set_req(i, op, a, b);
    bus.req_valid[2'(i)] = 1'b1;
    n = 0;
    do begin @(negedge t); n++; end while (!bus.req_ready[2'(i)] && n < 60);
    if (!bus.req_ready[2'(i)]) check("grant_timeout", 32'(bus.req_ready[2'(i)]), 1);
    @(posedge t); #1;
    bus.req_valid[2'(i)] = 1'b0;
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin @(negedge t); cyc++; end while (!bus.rsp_valid && cyc < 60);
    if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 1);
  endtask

  task automatic wait_grant(output int g);
    int n;
    n = 0;
    g = -1;
    do begin @(negedge t); n++; end while (bus.req_ready == '0 && n < 60);
    if (bus.req_ready == '0) check("grant_timeout", 32'(|bus.req_ready), 1);
    for (int i = 0; i < int'(NREQ); i++) if (bus.req_ready[2'(i)]) g = i;
  endtask

  task automatic run_op(input int i, input logic op, input logic [19:0] a,
                        input logic [19:0] b, input int eq, input int er,
                        input int eerr, input int elat);
    int c;
    send(i, op, a, b);
    wait_rsp(c);
    check("op_latency", 32'(c - 1), 32'(elat));
    check("op_id",  32'(bus.rsp_id), 32'(i));
    check("op_q",   32'(bus.rsp_q), 32'(eq));
    check("op_r",   32'(bus.rsp_r), 32'(er));
    check("op_err", 32'(bus.rsp_err), 32'(eerr));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c, g, go0;
    int exp_order[5];
    int exp_prod[5];
    exp_order = '{0, 1, 2, 3, 0};
    exp_prod  = '{10, 20, 30, 40, 10};

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge t);
    #1 rst_n = 1'b1;

    // Legal operations, including the largest legal operands/quotient.
    run_op(0, OP_MUL, 20'd517,    20'd141, 72897,   0,   0, 3);
    run_op(2, OP_DIV, 20'd72897,  20'd139, 524,     61,  0, 3);
    run_op(1, OP_MUL, 20'd1023,   20'd1023, 1046529, 0,  0, 3);
    run_op(3, OP_DIV, 20'd142335, 20'd139, 1023,    138, 0, 3);

    // Rejected operations never pulse the datapath trigger.
    go0 = go_cnt;
    run_op(1, OP_DIV, 20'd5,      20'd0,   0, 0, 1, 1);
    run_op(3, OP_MUL, 20'd1024,   20'd3,   0, 0, 1, 1);
    run_op(0, OP_DIV, 20'd142336, 20'd139, 0, 0, 1, 1);
    check("err_no_go", 32'(go_cnt - go0), 0);

    // Round robin with all requesters valid from reset.
    @(posedge t); #1 rst_n = 1'b0;
    repeat (2) @(posedge t);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, OP_MUL, 20'(i + 1), 20'd10);
    bus.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_grant(g);
      check("rr_order", 32'(g), 32'(exp_order[n]));
      if (n == 4) begin @(posedge t); #1 bus.req_valid = '0; end
      wait_rsp(c);
      check("rr_prod", 32'(bus.rsp_q), 32'(exp_prod[n]));
    end

    // Response back-pressure.
    @(posedge t); #1 bus.rsp_ready = 1'b0;
    send(3, OP_MUL, 20'd7, 20'd9);
    wait_rsp(c);
    @(posedge t); #1;
    set_req(1, OP_MUL, 20'd2, 20'd2);
    bus.req_valid[1] = 1'b1;
    repeat (5) begin
      @(negedge t);
      check("hold_valid", 32'(bus.rsp_valid), 1);
      check("hold_q",     32'(bus.rsp_q), 63);
      check("hold_id",    32'(bus.rsp_id), 3);
      check("hold_busy",  32'(busy), 1);
      check("hold_ready", 32'(bus.req_ready), 0);
    end
    @(posedge t); #1 bus.rsp_ready = 1'b1;
    @(negedge t);
    @(negedge t);
    check("after_hs_grant", 32'(bus.req_ready), 32'h2);
    @(posedge t); #1 bus.req_valid[1] = 1'b0;
    wait_rsp(c);
    check("after_hs_q", 32'(bus.rsp_q), 4);

    // Reset while waiting for the datapath drops the operation.
    send(2, OP_MUL, 20'd5, 20'd6);
    @(posedge t);
    @(posedge t); #1;
    check("wait_busy", 32'(busy), 1);
    rst_n = 1'b0;
    @(negedge t);
    check("rstmid_rsp_valid", 32'(bus.rsp_valid), 0);
    check("rstmid_dp_go",     32'(dp_go), 0);
    repeat (2) @(posedge t);
    #1 rst_n = 1'b1;
    set_req(0, OP_MUL, 20'd3, 20'd3);
    set_req(2, OP_MUL, 20'd4, 20'd4);
    bus.req_valid = 4'b0101;
    @(negedge t);
    check("rstmid_first_grant", 32'(bus.req_ready), 32'h1);
    @(posedge t); #1 bus.req_valid = '0;
    wait_rsp(c);
    check("rstmid_q",  32'(bus.rsp_q), 9);
    check("rstmid_id", 32'(bus.rsp_id), 0);
    @(posedge t); #1;
    repeat (2) @(negedge t);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
